imem_loader: RTL

Boot-time instruction memory writer for the single-cycle core. It accepts a byte stream from a host link over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them sequentially into the 16-entry instruction ROM array through a one-cycle write port, and releases the core (`core_run`) only after a checksum-verified load. It is the write-side counterpart of the core's instruction fetch path.

---
 rtl/imem_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles a checksummed byte stream
// into big-endian words and releases the core once the load verifies.
module imem_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              busy,
   output logic              core_run,
   output logic              load_err
);

   localparam int NB = DATA_W / 8;
   localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int AW1 = ADDR_W + 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);
   localparam logic [31:0] CAP = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state_q;
   logic [ADDR_W:0]   n_q;
   logic [ADDR_W:0]   waddr_q;
   logic [BC_W-1:0]   bcnt_q;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] word_d;
   logic [7:0]        csum_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [DATA_W-1:0] imem_wdata_q;
   logic              accept;
   logic              hdr_ok;

   // Ready comes only from the registered state, masked while in reset.
   assign byte_ready = reset && (state_q == S_IDLE ||
                                 state_q == S_DATA ||
                                 state_q == S_CHECK);
   assign accept = byte_valid && byte_ready;
   assign hdr_ok = (byte_data != 8'd0) && ({24'd0, byte_data} <= CAP);
   assign word_d = (word_q << 8) | DATA_W'(byte_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         waddr_q      <= '0;
         bcnt_q       <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
      end else begin
         imem_we_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (hdr_ok) begin
                     n_q     <= AW1'(byte_data);
                     waddr_q <= '0;
                     bcnt_q  <= '0;
                     csum_q  <= '0;
                     state_q <= S_DATA;
                  end else begin
                     state_q <= S_ERROR;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  word_q <= word_d;
                  csum_q <= csum_q ^ byte_data;
                  if (bcnt_q == BC_LAST) begin
                     bcnt_q       <= '0;
                     imem_we_q    <= 1'b1;
                     imem_addr_q  <= waddr_q[ADDR_W-1:0];
                     imem_wdata_q <= word_d;
                     waddr_q      <= waddr_q + 1'b1;
                     state_q      <= S_WRITE;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end
            S_WRITE: begin
               // waddr_q already counts the word being written.
               state_q <= (waddr_q == n_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
               if (accept) begin
                  state_q <= (byte_data == csum_q) ? S_DONE : S_ERROR;
               end
            end
            S_DONE:  state_q <= S_DONE;
            S_ERROR: state_q <= S_ERROR;
            default: state_q <= S_ERROR;
         endcase
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign busy       = (state_q == S_DATA) ||
                       (state_q == S_WRITE) ||
                       (state_q == S_CHECK);
   assign core_run   = (state_q == S_DONE);
   assign load_err   = (state_q == S_ERROR);

endmodule
